// File: rtl/mc_control_if.sv
// Unified memory port between the multicycle controller and memory.
// Latency: none, wires only; the controller holds its request until mem_resp.
// Backpressure: memory stalls the controller by holding mem_resp low.
interface mc_control_if;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_enable;
    logic       mem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        output mem_resp
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory and drives datapath selects.
// Latency: 5 cycles ALU/branch/jump, 7 cycles load/store with zero-wait memory; traps are sticky until reset.
// Backpressure: FETCH2/LD1/ST1 hold until mem_resp, bounded by MEM_TIMEOUT. Optional macro MC_CONTROL_MISALIGN_TRAP_EN.
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100,
        bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000, sh = 3'b001, sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
        axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [1:0] {
        pcmux_pc_plus4 = 2'b00, pcmux_alu_out = 2'b01, pcmux_alu_mod2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic {
        a1_rs1_out = 1'b0, a1_pc_out = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        a2_i_imm = 3'd0, a2_u_imm = 3'd1, a2_b_imm = 3'd2,
        a2_s_imm = 3'd3, a2_j_imm = 3'd4, a2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw = 4'd3,
        rf_pc_plus4 = 4'd4, rf_lb = 4'd5, rf_lbu = 4'd6, rf_lh = 4'd7, rf_lhu = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        mar_pc_out = 1'b0, mar_alu_out = 1'b1
    } marmux_sel_t;

    typedef enum logic {
        cmp_rs2_out = 1'b0, cmp_i_imm = 1'b1
    } cmpmux_sel_t;
endpackage

module mc_control
    import rv32i_types::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  rv32i_opcode         opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                br_en,
    input  logic [1:0]          addr_lo,
    mc_control_if.master        mem,
    output pcmux_sel_t          pcmux_sel,
    output alumux1_sel_t        alumux1_sel,
    output alumux2_sel_t        alumux2_sel,
    output regfilemux_sel_t     regfilemux_sel,
    output marmux_sel_t         marmux_sel,
    output cmpmux_sel_t         cmpmux_sel,
    output alu_ops              aluop,
    output branch_funct3_t      cmpop,
    output logic                load_pc,
    output logic                load_ir,
    output logic                load_regfile,
    output logic                load_mar,
    output logic                load_mdr,
    output logic                load_data_out,
    output logic                commit,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC, S_CALC_ADDR,
        S_LD1, S_LD2, S_ST1, S_ST2, S_TRAP
    } state_t;

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    state_t          state;
    state_t          state_next;
    logic [1:0]      cause_next;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      off;
    logic            wait_state;
    logic            enter_wait;
    logic            timeout;
    logic            is_store;
    logic            br_f3_ok;
    logic            ld_f3_ok;
    logic            st_f3_ok;
    logic            misalign;
    logic [3:0]      st_mask;
    logic            unused_funct7;

    // Only funct7[5] carries meaning for the supported ALU ops.
    assign unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

    assign is_store   = (opcode == op_store);
    assign wait_state = (state == S_FETCH2) || (state == S_LD1) || (state == S_ST1);
    assign enter_wait = (state_next != state) &&
                        ((state_next == S_FETCH2) || (state_next == S_LD1) || (state_next == S_ST1));
    // A response on the last allowed cycle still counts as normal progress.
    assign timeout    = TO_EN && wait_state && !mem.mem_resp && (to_cnt == TO_LAST);

    assign br_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    assign ld_f3_ok = (funct3 == lb) || (funct3 == lh) || (funct3 == lw) ||
                      (funct3 == lbu) || (funct3 == lhu);
    assign st_f3_ok = (funct3 == sb) || (funct3 == sh) || (funct3 == sw);

    // Alignment check on the live ALU address bits while in CALC_ADDR.
`ifdef MC_CONTROL_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (funct3 == 3'b010)
            misalign = (addr_lo != 2'b00);
        else if ((funct3 == lh) || (!is_store && (funct3 == lhu)))
            misalign = addr_lo[0];
    end
`else
    assign misalign = 1'b0;
`endif

    // Store byte lanes from the offset captured in CALC_ADDR; halfwords ignore off[0].
    always_comb begin
        st_mask = 4'b1111;
        case (funct3)
            sb:      st_mask = 4'b0001 << off;
            sh:      st_mask = 4'b0011 << {off[1], 1'b0};
            default: st_mask = 4'b1111;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH1;
        else      state <= state_next;
    end

    // Timeout counter, captured offset, sticky trap cause and retirement counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt     <= '0;
            off        <= 2'b00;
            trap_cause <= CAUSE_ILLEGAL;
            retire_cnt <= '0;
        end else begin
            if (enter_wait)
                to_cnt <= '0;
            else if (wait_state && !mem.mem_resp)
                to_cnt <= to_cnt + TO_W'(1);
            if (state == S_CALC_ADDR)
                off <= addr_lo;
            if ((state != S_TRAP) && (state_next == S_TRAP))
                trap_cause <= cause_next;
            if ((state == S_EXEC) || (state == S_LD2) || (state == S_ST2))
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Next-state logic and the cause recorded on entry to TRAP.
    always_comb begin
        state_next = state;
        cause_next = CAUSE_ILLEGAL;
        case (state)
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: begin
                if (mem.mem_resp) state_next = S_FETCH3;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_FETCH3: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    op_lui, op_auipc, op_imm, op_reg, op_jal, op_jalr:
                        state_next = S_EXEC;
                    op_br:    state_next = br_f3_ok ? S_EXEC : S_TRAP;
                    op_load:  state_next = ld_f3_ok ? S_CALC_ADDR : S_TRAP;
                    op_store: state_next = st_f3_ok ? S_CALC_ADDR : S_TRAP;
                    default:  state_next = S_TRAP;
                endcase
            end
            S_EXEC: state_next = S_FETCH1;
            S_CALC_ADDR: begin
                if (misalign) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_MISALIGN;
                end else begin
                    state_next = is_store ? S_ST1 : S_LD1;
                end
            end
            S_LD1, S_ST1: begin
                if (mem.mem_resp) state_next = (state == S_LD1) ? S_LD2 : S_ST2;
                else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_LD2, S_ST2: state_next = S_FETCH1;
            S_TRAP:       state_next = S_TRAP;
            default:      state_next = S_FETCH1;
        endcase
    end

    // Datapath selects, load strobes and memory requests; all strobes held low during reset.
    always_comb begin
        pcmux_sel           = pcmux_pc_plus4;
        alumux1_sel         = a1_rs1_out;
        alumux2_sel         = a2_i_imm;
        regfilemux_sel      = rf_alu_out;
        marmux_sel          = mar_pc_out;
        cmpmux_sel          = cmp_rs2_out;
        aluop               = alu_ops'(funct3);
        cmpop               = branch_funct3_t'(funct3);
        load_pc             = 1'b0;
        load_ir             = 1'b0;
        load_regfile        = 1'b0;
        load_mar            = 1'b0;
        load_mdr            = 1'b0;
        load_data_out       = 1'b0;
        commit              = 1'b0;
        mem.mem_read        = 1'b0;
        mem.mem_write       = 1'b0;
        mem.mem_byte_enable = 4'b0000;
        trap                = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH1: load_mar = 1'b1;
                S_FETCH2: begin
                    mem.mem_read        = 1'b1;
                    mem.mem_byte_enable = 4'b1111;
                    load_mdr            = 1'b1;
                end
                S_FETCH3: load_ir = 1'b1;
                S_EXEC: begin
                    commit  = 1'b1;
                    load_pc = 1'b1;
                    case (opcode)
                        op_lui: begin
                            load_regfile   = 1'b1;
                            regfilemux_sel = rf_u_imm;
                        end
                        op_auipc: begin
                            load_regfile = 1'b1;
                            alumux1_sel  = a1_pc_out;
                            alumux2_sel  = a2_u_imm;
                            aluop        = alu_add;
                        end
                        op_imm, op_reg: begin
                            load_regfile = 1'b1;
                            if (opcode == op_reg) alumux2_sel = a2_rs2_out;
                            case (funct3)
                                add: if (opcode == op_reg && funct7[5]) aluop = alu_sub;
                                slt: begin
                                    cmpop          = blt;
                                    regfilemux_sel = rf_br_en;
                                    if (opcode == op_imm) cmpmux_sel = cmp_i_imm;
                                end
                                sltu: begin
                                    cmpop          = bltu;
                                    regfilemux_sel = rf_br_en;
                                    if (opcode == op_imm) cmpmux_sel = cmp_i_imm;
                                end
                                sr:      aluop = funct7[5] ? alu_sra : alu_srl;
                                default: ;
                            endcase
                        end
                        op_br: begin
                            alumux1_sel = a1_pc_out;
                            alumux2_sel = a2_b_imm;
                            aluop       = alu_add;
                            pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
                        end
                        op_jal, op_jalr: begin
                            load_regfile   = 1'b1;
                            regfilemux_sel = rf_pc_plus4;
                            pcmux_sel      = pcmux_alu_mod2;
                            aluop          = alu_add;
                            if (opcode == op_jal) begin
                                alumux1_sel = a1_pc_out;
                                alumux2_sel = a2_j_imm;
                            end
                        end
                        default: ;
                    endcase
                end
                S_CALC_ADDR: begin
                    aluop       = alu_add;
                    alumux2_sel = is_store ? a2_s_imm : a2_i_imm;
                    if (!misalign) begin
                        load_mar      = 1'b1;
                        marmux_sel    = mar_alu_out;
                        load_data_out = is_store;
                    end
                end
                S_LD1: begin
                    mem.mem_read        = 1'b1;
                    mem.mem_byte_enable = 4'b1111;
                    load_mdr            = 1'b1;
                end
                S_LD2: begin
                    commit       = 1'b1;
                    load_pc      = 1'b1;
                    load_regfile = 1'b1;
                    case (funct3)
                        lb:      regfilemux_sel = rf_lb;
                        lh:      regfilemux_sel = rf_lh;
                        lbu:     regfilemux_sel = rf_lbu;
                        lhu:     regfilemux_sel = rf_lhu;
                        default: regfilemux_sel = rf_lw;
                    endcase
                end
                S_ST1: begin
                    mem.mem_write       = 1'b1;
                    mem.mem_byte_enable = st_mask;
                end
                S_ST2: begin
                    commit  = 1'b1;
                    load_pc = 1'b1;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control with a 4-cycle memory timeout and 4-bit retire counter.
module tb_mc_control;
    import rv32i_types::*;

    localparam int TO = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic [1:0]      addr_lo;
    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic            commit;
    logic [CW-1:0]   retire_cnt;
    logic            trap;
    logic [1:0]      trap_cause;

    mc_control_if mif ();

    mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .addr_lo(addr_lo), .mem(mif.master),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_data_out(load_data_out), .commit(commit), .retire_cnt(retire_cnt),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            cyc;
    logic [CW-1:0] exp_ret;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Advance until commit is seen; cycles counted from the current (FETCH1) cycle, -1 if never.
    task automatic run_until_commit(input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            if (commit) begin
                cycles = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        tests++; if (mif.mem_read !== 1'b0) begin fails++; $display("FAIL rst_mem_read got %b exp 0", mif.mem_read); end
        tests++; if (load_mar !== 1'b0) begin fails++; $display("FAIL rst_load_mar got %b exp 0", load_mar); end
        tests++; if (retire_cnt !== 4'd0) begin fails++; $display("FAIL rst_retire got %0d exp 0", retire_cnt); end
        tests++; if ({trap, trap_cause} !== 3'b000) begin fails++; $display("FAIL rst_trap got %b exp 000", {trap, trap_cause}); end
        tick();
        tick();
        tests++; if ({load_mar, mif.mem_read, commit} !== 3'b000) begin fails++; $display("FAIL rst_held_strobes got %b exp 000", {load_mar, mif.mem_read, commit}); end
        rst = 1'b1;
        #1;
        tests++; if (load_mar !== 1'b1 || marmux_sel !== mar_pc_out) begin fails++; $display("FAIL rst_first_fetch got load_mar=%b marmux=%0d exp 1/0", load_mar, marmux_sel); end
        exp_ret = '0;
    endtask

    task automatic test_add_sub();
        mif.mem_resp = 1'b1;
        opcode = op_reg; funct3 = 3'b000; funct7 = 7'h00;
        run_until_commit(20, cyc);
        tests++; if (cyc !== 4) begin fails++; $display("FAIL add_latency got %0d exp 4", cyc); end
        tests++; if (aluop !== alu_add || load_regfile !== 1'b1 || alumux2_sel !== a2_rs2_out) begin fails++; $display("FAIL add_ctrl got aluop=%0d ldrf=%b a2=%0d", aluop, load_regfile, alumux2_sel); end
        exp_ret++;
        tick();
        funct7 = 7'h20;
        run_until_commit(20, cyc);
        tests++; if (cyc !== 4) begin fails++; $display("FAIL sub_latency got %0d exp 4", cyc); end
        tests++; if (aluop !== alu_sub) begin fails++; $display("FAIL sub_aluop got %0d exp %0d", aluop, alu_sub); end
        exp_ret++;
        tick();
        tests++; if (retire_cnt !== exp_ret) begin fails++; $display("FAIL addsub_retire got %0d exp %0d", retire_cnt, exp_ret); end
    endtask

    task automatic test_branch_jump();
        opcode = op_br; funct3 = 3'b000; funct7 = 7'h00; br_en = 1'b1;
        run_until_commit(20, cyc);
        tests++; if (cyc !== 4 || pcmux_sel !== pcmux_alu_out || alumux2_sel !== a2_b_imm || load_regfile !== 1'b0) begin fails++; $display("FAIL br_taken got cyc=%0d pcmux=%0d a2=%0d ldrf=%b", cyc, pcmux_sel, alumux2_sel, load_regfile); end
        exp_ret++;
        tick();
        br_en = 1'b0;
        run_until_commit(20, cyc);
        tests++; if (pcmux_sel !== pcmux_pc_plus4) begin fails++; $display("FAIL br_not_taken got pcmux=%0d exp 0", pcmux_sel); end
        exp_ret++;
        tick();
        opcode = op_jal;
        run_until_commit(20, cyc);
        tests++; if (pcmux_sel !== pcmux_alu_mod2 || regfilemux_sel !== rf_pc_plus4 || alumux2_sel !== a2_j_imm) begin fails++; $display("FAIL jal_ctrl got pcmux=%0d rf=%0d a2=%0d", pcmux_sel, regfilemux_sel, alumux2_sel); end
        exp_ret++;
        tick();
        tests++; if (retire_cnt !== exp_ret) begin fails++; $display("FAIL brj_retire got %0d exp %0d", retire_cnt, exp_ret); end
    endtask

    task automatic test_store_sb();
        opcode = op_store; funct3 = 3'b000; addr_lo = 2'b11; mif.mem_resp = 1'b1;
        repeat (4) tick();
        tests++; if (load_data_out !== 1'b1 || load_mar !== 1'b1 || marmux_sel !== mar_alu_out || alumux2_sel !== a2_s_imm) begin fails++; $display("FAIL sb_calc got ldo=%b mar=%b mm=%0d a2=%0d", load_data_out, load_mar, marmux_sel, alumux2_sel); end
        mif.mem_resp = 1'b0;
        tick();
        tests++; if (mif.mem_write !== 1'b1 || mif.mem_byte_enable !== 4'b1000) begin fails++; $display("FAIL sb_st1 got wr=%b be=%b exp 1/1000", mif.mem_write, mif.mem_byte_enable); end
        repeat (3) tick();
        tests++; if (mif.mem_write !== 1'b1 || trap !== 1'b0) begin fails++; $display("FAIL sb_wait got wr=%b trap=%b exp 1/0", mif.mem_write, trap); end
        mif.mem_resp = 1'b1;
        tick();
        tests++; if (commit !== 1'b1 || load_pc !== 1'b1 || mif.mem_write !== 1'b0) begin fails++; $display("FAIL sb_st2 got commit=%b ldpc=%b wr=%b", commit, load_pc, mif.mem_write); end
        exp_ret++;
        tick();
        tests++; if (retire_cnt !== exp_ret || load_mar !== 1'b1) begin fails++; $display("FAIL sb_retire got %0d exp %0d", retire_cnt, exp_ret); end
    endtask

    task automatic test_store_sh();
        opcode = op_store; funct3 = 3'b001; addr_lo = 2'b10; mif.mem_resp = 1'b1;
        repeat (5) tick();
        tests++; if (mif.mem_write !== 1'b1 || mif.mem_byte_enable !== 4'b1100) begin fails++; $display("FAIL sh_be got wr=%b be=%b exp 1/1100", mif.mem_write, mif.mem_byte_enable); end
        tick();
        exp_ret++;
        tick();
    endtask

    task automatic test_load_lw();
        opcode = op_load; funct3 = 3'b010; addr_lo = 2'b10; mif.mem_resp = 1'b1;
        repeat (4) tick();
        tick();
`ifdef MC_CONTROL_MISALIGN_TRAP_EN
        tests++; if (trap !== 1'b1 || trap_cause !== 2'd1 || mif.mem_read !== 1'b0) begin fails++; $display("FAIL lw_misalign got trap=%b cause=%0d rd=%b exp 1/1/0", trap, trap_cause, mif.mem_read); end
        do_reset();
        exp_ret = '0;
`else
        tests++; if (mif.mem_read !== 1'b1 || mif.mem_byte_enable !== 4'b1111) begin fails++; $display("FAIL lw_ld1 got rd=%b be=%b exp 1/1111", mif.mem_read, mif.mem_byte_enable); end
        tick();
        tests++; if (commit !== 1'b1 || load_regfile !== 1'b1 || regfilemux_sel !== rf_lw || load_pc !== 1'b1) begin fails++; $display("FAIL lw_ld2 got commit=%b ldrf=%b rf=%0d", commit, load_regfile, regfilemux_sel); end
        exp_ret++;
        tick();
        tests++; if (retire_cnt !== exp_ret) begin fails++; $display("FAIL lw_retire got %0d exp %0d", retire_cnt, exp_ret); end
`endif
    endtask

    task automatic test_fetch_resp_last();
        opcode = op_imm; funct3 = 3'b000; mif.mem_resp = 1'b0;
        repeat (4) tick();
        tests++; if (mif.mem_read !== 1'b1 || trap !== 1'b0) begin fails++; $display("FAIL f2_last_wait got rd=%b trap=%b exp 1/0", mif.mem_read, trap); end
        mif.mem_resp = 1'b1;
        tick();
        tests++; if (load_ir !== 1'b1 || trap !== 1'b0) begin fails++; $display("FAIL f2_resp_wins got ldir=%b trap=%b exp 1/0", load_ir, trap); end
        tick();
        tick();
        tests++; if (commit !== 1'b1) begin fails++; $display("FAIL f2_then_exec got commit=%b exp 1", commit); end
        exp_ret++;
        tick();
    endtask

    task automatic test_reset_mid_ld1();
        opcode = op_load; funct3 = 3'b010; addr_lo = 2'b00; mif.mem_resp = 1'b1;
        repeat (4) tick();
        mif.mem_resp = 1'b0;
        tick();
        tests++; if (mif.mem_read !== 1'b1) begin fails++; $display("FAIL ld1_pre got rd=%b exp 1", mif.mem_read); end
        #1 rst = 1'b0;
        #1;
        tests++; if (mif.mem_read !== 1'b0 || retire_cnt !== 4'd0 || load_mar !== 1'b0) begin fails++; $display("FAIL ld1_rst got rd=%b ret=%0d mar=%b exp 0/0/0", mif.mem_read, retire_cnt, load_mar); end
        tick();
        tests++; if (mif.mem_read !== 1'b0) begin fails++; $display("FAIL ld1_rst_edge got rd=%b exp 0", mif.mem_read); end
        rst = 1'b1;
        #1;
        tests++; if (load_mar !== 1'b1 || mif.mem_read !== 1'b0) begin fails++; $display("FAIL ld1_resume_f1 got mar=%b rd=%b exp 1/0", load_mar, mif.mem_read); end
        exp_ret = '0;
        mif.mem_resp = 1'b1;
        tick();
        tests++; if (mif.mem_read !== 1'b1) begin fails++; $display("FAIL ld1_resume_f2 got rd=%b exp 1", mif.mem_read); end
        run_until_commit(20, cyc);
        tests++; if (cyc !== 5) begin fails++; $display("FAIL ld_latency got %0d exp 5 from FETCH2", cyc); end
        exp_ret++;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        exp_ret = '0;
        opcode = op_lui; mif.mem_resp = 1'b1;
        for (int k = 0; k < 16; k++) begin
            run_until_commit(20, cyc);
            if (k == 0) begin
                tests++; if (regfilemux_sel !== rf_u_imm || load_regfile !== 1'b1) begin fails++; $display("FAIL lui_ctrl got rf=%0d ldrf=%b", regfilemux_sel, load_regfile); end
            end
            exp_ret++;
            tick();
            if (k == 14) begin
                tests++; if (retire_cnt !== 4'd15) begin fails++; $display("FAIL wrap_max got %0d exp 15", retire_cnt); end
            end
        end
        tests++; if (retire_cnt !== 4'd0 || retire_cnt !== exp_ret) begin fails++; $display("FAIL wrap_zero got %0d exp 0", retire_cnt); end
    endtask

    task automatic test_timeout();
        opcode = op_imm; funct3 = 3'b000; mif.mem_resp = 1'b0;
        repeat (4) tick();
        tests++; if (trap !== 1'b0 || mif.mem_read !== 1'b1) begin fails++; $display("FAIL to_before got trap=%b rd=%b exp 0/1", trap, mif.mem_read); end
        tick();
        tests++; if (trap !== 1'b1 || trap_cause !== 2'd2 || mif.mem_read !== 1'b0) begin fails++; $display("FAIL to_trap got trap=%b cause=%0d rd=%b exp 1/2/0", trap, trap_cause, mif.mem_read); end
        do_reset();
        exp_ret = '0;
        tests++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin fails++; $display("FAIL to_cleared got trap=%b cause=%0d exp 0/0", trap, trap_cause); end
    endtask

    task automatic test_illegal();
        opcode = rv32i_opcode'(7'b0001111); funct3 = 3'b000; mif.mem_resp = 1'b1;
        repeat (4) tick();
        tests++; if (trap !== 1'b1 || trap_cause !== 2'd0) begin fails++; $display("FAIL ill_trap got trap=%b cause=%0d exp 1/0", trap, trap_cause); end
        for (int i = 0; i < 20; i++) begin
            mif.mem_resp = i[0];
            tick();
            tests++;
            if ({load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, commit,
                 mif.mem_read, mif.mem_write, trap} !== 10'b0000000001) begin
                fails++;
                $display("FAIL ill_quiet cycle %0d got %b exp 0000000001", i,
                         {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, commit,
                          mif.mem_read, mif.mem_write, trap});
            end
        end
        tests++; if (retire_cnt !== exp_ret || trap_cause !== 2'd0) begin fails++; $display("FAIL ill_hold got ret=%0d cause=%0d exp %0d/0", retire_cnt, trap_cause, exp_ret); end
    endtask

    initial begin
        opcode = op_lui; funct3 = 3'b000; funct7 = 7'h00; br_en = 1'b0; addr_lo = 2'b00;
        mif.mem_resp = 1'b0;
        exp_ret = '0;
        test_reset();
        test_add_sub();
        test_branch_jump();
        test_store_sb();
        test_store_sh();
        test_load_lw();
        test_fetch_resp_last();
        test_reset_mid_ld1();
        test_wrap();
        test_timeout();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
